// File: rtl/spart_pkg.sv
// spart_pkg: shared state encoding and SPART register addresses
package spart_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, XFER} arb_state_t;
  localparam logic [1:0] ADDR_TXRX   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DB_LO  = 2'b10;
  localparam logic [1:0] ADDR_DB_HI  = 2'b11;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set bit at or after ptr
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_mask_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  logic found;
  // scan from ptr upward with wrap, keep only the first hit
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_mask_i[(int'(ptr_i) + i) % N]) begin
        gnt_o[(int'(ptr_i) + i) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spart_bus_arbiter.sv
// spart_bus_arbiter: round-robin sharing of the SPART processor bus with divisor lock and timeout
module spart_bus_arbiter
  import spart_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_rw,
  input  logic [2*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   err,
  output logic [7:0]         rdata,
  output logic               iocs,
  output logic               iorw,
  output logic [1:0]         ioaddr,
  inout  wire  [7:0]         databus,
  input  logic               rda,
  input  logic               tbr
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  arb_state_t state_q, state_d;
  logic [PW-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, win_idx, nxt_ptr;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d, elig, win_oh, own_oh;
  logic [7:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0] addr_q, addr_d;
  logic rw_q, rw_d, lock_q, lock_d, ready, timeout_hit;
  assign own_oh      = N_REQ'(1) << owner_q;
  assign elig        = lock_q ? (req & own_oh) : req;
  assign nxt_ptr     = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign ready       = (addr_q == ADDR_TXRX) ? (rw_q ? rda : tbr) : 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (32'(wait_cnt_q) + 32'd1 == 32'(TIMEOUT));
  assign gnt         = gnt_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign iocs        = (state_q == XFER);
  assign iorw        = (state_q == XFER) ? rw_q : 1'b1;
  assign ioaddr      = (state_q == XFER) ? addr_q : 2'b00;
  assign databus     = (state_q == XFER && !rw_q) ? wdata_q : 'z;
  rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
    .req_mask_i(elig),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (win_oh)
  );
  // binary index of the one-hot winner
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) win_idx = win_oh[i] ? PW'(i) : win_idx;
  end
  // next-state: grant and latch in IDLE, gate on rda/tbr in WAIT, one-cycle bus strobe in XFER
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    lock_d     = lock_q;
    rr_ptr_d   = rr_ptr_q;
    rdata_d    = rdata_q;
    gnt_d      = '0;
    done_d     = '0;
    err_d      = '0;
    case (state_q)
      IDLE: if (|elig) begin
        state_d    = WAIT;
        owner_d    = win_idx;
        rw_d       = req_rw[win_idx];
        addr_d     = req_addr[2*win_idx +: 2];
        wdata_d    = req_wdata[8*win_idx +: 8];
        wait_cnt_d = '0;
        gnt_d      = win_oh;
      end
      WAIT: if (ready) begin
        state_d    = XFER;
        wait_cnt_d = '0;
      end else if (timeout_hit) begin
        state_d    = IDLE;
        wait_cnt_d = '0;
        err_d      = own_oh;
        lock_d     = 1'b0;
        rr_ptr_d   = nxt_ptr;
      end else if (TIMEOUT != 0) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
      XFER: begin
        state_d  = IDLE;
        done_d   = own_oh;
        rr_ptr_d = nxt_ptr;
        rdata_d  = rw_q ? databus : rdata_q;
        lock_d   = (!rw_q && addr_q == ADDR_DB_LO) ? 1'b1 :
                   (!rw_q && addr_q == ADDR_DB_HI) ? 1'b0 : lock_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and operand registers; reset releases the bus and drops any pending pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rw_q       <= 1'b1;
      addr_q     <= 2'b00;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      lock_q     <= 1'b0;
      rr_ptr_q   <= '0;
      rdata_q    <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      lock_q     <= lock_d;
      rr_ptr_q   <= rr_ptr_d;
      rdata_q    <= rdata_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_spart_bus_arbiter.sv
// tb_spart_bus_arbiter: scoreboard bench for the SPART bus arbiter
module tb_spart_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req = '0, req_rw = '0;
  logic [3:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0] gnt, done, err;
  logic [7:0] rdata, spart_rd = 8'h00;
  logic iocs, iorw, rda = 1'b0, tbr = 1'b1;
  logic [1:0] ioaddr;
  wire [7:0] databus;
  int total = 0, bad = 0;
  typedef struct {int kind; int idx; logic rd; logic [7:0] data;} exp_t;
  exp_t q[$];

  assign databus = (iocs && iorw) ? spart_rd : 'z;
  always #5 clk = ~clk;

  spart_bus_arbiter #(.N_REQ(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus), .rda(rda), .tbr(tbr)
  );

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic push(input int k, input int i, input logic rd, input logic [7:0] d);
    exp_t e;
    e.kind = k; e.idx = i; e.rd = rd; e.data = d;
    q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic rw, input logic [1:0] a, input logic [7:0] d);
    req_rw[i] = rw;
    req_addr[2*i +: 2] = a;
    req_wdata[8*i +: 8] = d;
    req[i] = 1'b1;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic mon(input int kind, input logic [1:0] v);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL sb unexpected: kind=%0d vec=%b", kind, v);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || v != (2'b01 << e.idx) || (e.rd && rdata != e.data)) begin
        bad++;
        $display("FAIL sb: got kind=%0d vec=%b rdata=%h want kind=%0d idx=%0d rdata=%h",
                 kind, v, rdata, e.kind, e.idx, e.data);
      end
    end
  endtask

  // kind 0=gnt 1=done 2=err
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt != 0) mon(0, gnt);
      if (done != 0) mon(1, done);
      if (err != 0) mon(2, err);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nxt(); nxt();
    chk("rst iocs", {7'd0, iocs}, 8'd0);
    chk("rst iorw", {7'd0, iorw}, 8'd1);
    chk("rst ioaddr", {6'd0, ioaddr}, 8'd0);
    chk("rst gnt", {6'd0, gnt}, 8'd0);
    chk("rst done_err", {4'd0, done, err}, 8'd0);
    chk("rst rdata", rdata, 8'h00);
    rst_n = 1'b1;
    nxt();
    // 1: TX write with tbr=1
    set_req(0, 1'b0, 2'b00, 8'h41);
    push(0, 0, 1'b0, 8'h00); push(1, 0, 1'b0, 8'h00);
    nxt(); chk("t1 gnt", {6'd0, gnt}, 8'h01); req = '0;
    nxt(); chk("t1 iocs", {7'd0, iocs}, 8'd1); chk("t1 iorw", {7'd0, iorw}, 8'd0); chk("t1 data", databus, 8'h41);
    nxt(); chk("t1 done", {6'd0, done}, 8'h01); chk("t1 idle iocs", {7'd0, iocs}, 8'd0);
    // 2: RX read gated by rda
    set_req(1, 1'b1, 2'b00, 8'h00);
    push(0, 1, 1'b0, 8'h00); push(1, 1, 1'b1, 8'h5A);
    nxt(); chk("t2 gnt", {6'd0, gnt}, 8'h02); req = '0;
    chk("t2 wait iocs", {7'd0, iocs}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      nxt(); chk("t2 wait iocs", {7'd0, iocs}, 8'd0);
    end
    rda = 1'b1; spart_rd = 8'h5A;
    nxt(); chk("t2 xfer iocs", {7'd0, iocs}, 8'd1); chk("t2 xfer iorw", {7'd0, iorw}, 8'd1);
    nxt(); chk("t2 done", {6'd0, done}, 8'h02); chk("t2 rdata", rdata, 8'h5A);
    rda = 1'b0; spart_rd = 8'h00;
    // 3: round robin with both requesting
    set_req(0, 1'b0, 2'b00, 8'hA0); set_req(1, 1'b0, 2'b00, 8'hB1);
    for (int t = 0; t < 4; t++) begin
      push(0, t % 2, 1'b0, 8'h00); push(1, t % 2, 1'b0, 8'h00);
    end
    for (int t = 0; t < 4; t++) begin
      nxt(); chk("t3 gnt order", {6'd0, gnt}, (t % 2) ? 8'h02 : 8'h01);
      if (t == 3) req = '0;
      nxt(); chk("t3 data", databus, (t % 2) ? 8'hB1 : 8'hA0);
      nxt();
    end
    chk("t3 rdata held", rdata, 8'h5A);
    // 4: divisor lock
    set_req(0, 1'b0, 2'b10, 8'h44); set_req(1, 1'b0, 2'b00, 8'h77);
    push(0, 0, 1'b0, 8'h00); push(1, 0, 1'b0, 8'h00);
    push(0, 0, 1'b0, 8'h00); push(1, 0, 1'b0, 8'h00);
    push(0, 1, 1'b0, 8'h00); push(1, 1, 1'b0, 8'h00);
    nxt(); chk("t4 gnt lo", {6'd0, gnt}, 8'h01);
    set_req(0, 1'b0, 2'b11, 8'h01);
    nxt(); chk("t4 addr lo", {6'd0, ioaddr}, 8'h02); chk("t4 data lo", databus, 8'h44);
    nxt();
    nxt(); chk("t4 gnt hi locked", {6'd0, gnt}, 8'h01); req[0] = 1'b0;
    nxt(); chk("t4 addr hi", {6'd0, ioaddr}, 8'h03); chk("t4 data hi", databus, 8'h01);
    nxt(); chk("t4 no gnt at done", {6'd0, gnt}, 8'h00);
    nxt(); chk("t4 gnt1 after unlock", {6'd0, gnt}, 8'h02); req[1] = 1'b0;
    nxt(); chk("t4 data1", databus, 8'h77);
    nxt();
    // 5: timeout with tbr=0
    tbr = 1'b0;
    set_req(0, 1'b0, 2'b00, 8'h33);
    push(0, 0, 1'b0, 8'h00); push(2, 0, 1'b0, 8'h00);
    nxt(); chk("t5 gnt", {6'd0, gnt}, 8'h01); req = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) nxt();
      chk("t5 wait iocs", {7'd0, iocs}, 8'd0);
      chk("t5 wait err", {6'd0, err}, 8'h00);
    end
    nxt(); chk("t5 err", {6'd0, err}, 8'h01); chk("t5 no done", {6'd0, done}, 8'h00);
    // 6: rr_ptr moved to 1, then reset during XFER
    tbr = 1'b1;
    set_req(0, 1'b0, 2'b00, 8'h55); set_req(1, 1'b0, 2'b00, 8'hC3);
    push(0, 1, 1'b0, 8'h00);
    nxt(); chk("t6 gnt1 ptr", {6'd0, gnt}, 8'h02); req[1] = 1'b0;
    nxt(); chk("t6 xfer iocs", {7'd0, iocs}, 8'd1); chk("t6 xfer data", databus, 8'hC3);
    rst_n = 1'b0;
    #1;
    chk("t6 rst iocs", {7'd0, iocs}, 8'd0); chk("t6 rst iorw", {7'd0, iorw}, 8'd1);
    nxt(); chk("t6 rst no pulse", {4'd0, done, err}, 8'h00);
    nxt();
    push(0, 0, 1'b0, 8'h00); push(1, 0, 1'b0, 8'h00);
    rst_n = 1'b1; req[1] = 1'b1;
    nxt(); chk("t6 gnt0 after rst", {6'd0, gnt}, 8'h01); req = '0;
    nxt(); chk("t6 data0", databus, 8'h55);
    nxt(); chk("t6 done0", {6'd0, done}, 8'h01);
    nxt(); nxt();
    chk("sb drained", 8'(q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
